datmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves word loads and stores from the processor's load/store path over a valid/ready request/response handshake. It replaces the zero-latency combinational data-memory array. It holds a byte-addressed, big-endian store and applies a configurable access latency, so the core can be tested against slow memory. One request is outstanding at a time.

---
 rtl/datmem_resp_pkg.sv | 13 +
 rtl/be_word_mem.sv | 35 +++
 rtl/datmem_responder.sv | 95 +++++++++
 tb/tb_datmem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/datmem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package datmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/be_word_mem.sv
// Big-endian byte array: one synchronous 4-lane word write port and one
// asynchronous word read port; lane addresses wrap modulo 2^ADDR_W.
module be_word_mem
  import datmem_resp_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] mem_q [2**ADDR_W];

  // NOTE: storage has no reset so it maps onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_q[waddr + ADDR_W'(i)] <= wdata[8*(WORD_BYTES-1-i) +: 8];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata[8*(WORD_BYTES-1-i) +: 8] = mem_q[raddr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/datmem_responder.sv
// Multi-cycle word load/store responder with a configurable access latency
// and one outstanding request over valid/ready request/response handshakes.
module datmem_responder
  import datmem_resp_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [31:0]       resp_rdata
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic              resp_write_q;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       mem_rdata;
  logic              commit;
  logic              mem_we;

  assign commit = (state_q == WAIT) && (cnt_q == '0);
  // Reset on the commit edge must suppress the store.
  assign mem_we = commit && write_q && !rst;

  be_word_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(LATENCY - 1);
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_write_q <= write_q;
            resp_rdata_q <= write_q ? 32'h0 : mem_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_datmem_responder.sv
// Directed bench for datmem_responder: LATENCY=2 instance for function and
// reset cases, LATENCY=1 instance for back-to-back request spacing.
module tb_datmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_write;
  logic [31:0] resp_rdata;

  logic        req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b0;
  logic [4:0]  req_addr1 = '0;
  logic [31:0] req_wdata1 = '0;
  logic        req_ready1, resp_valid1, resp_write1;
  logic [31:0] resp_rdata1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  datmem_responder #(.ADDR_W(5), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_write(resp_write), .resp_rdata(resp_rdata)
  );

  datmem_responder #(.ADDR_W(5), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_write(resp_write1), .resp_rdata(resp_rdata1)
  );

  // Issue one request on dut, wait (bounded) for its response and take it.
  // lat counts edges from accept to the first cycle with resp_valid seen.
  task automatic transact(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic rw, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata; rw = resp_write;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_write !== 1'b0) begin fails++; $display("FAIL reset_resp_write: got %b want 0", resp_write); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
  endtask

  task automatic test_load_basic;
    logic [31:0] rd; logic rw; int lat;
    transact(1'b1, 5'd0, 32'h12345678, rd, rw, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL store0_rdata: got %h want 0", rd); end
    tests++; if (rw !== 1'b1) begin fails++; $display("FAIL store0_write: got %b want 1", rw); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL store0_latency: got %0d want 3", lat); end
    transact(1'b0, 5'd0, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL load0_rdata: got %h want 12345678", rd); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL load0_write: got %b want 0", rw); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL load0_latency: got %0d want 3", lat); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic rw; int lat;
    transact(1'b1, 5'd12, 32'h0, rd, rw, lat);
    transact(1'b1, 5'd8, 32'hDEADBEEF, rd, rw, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL store8_rdata: got %h want 0", rd); end
    transact(1'b0, 5'd8, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load8: got %h want deadbeef", rd); end
    // Byte-offset load exposes the individual byte placement mem[10..13].
    transact(1'b0, 5'd10, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'hBEEF0000) begin fails++; $display("FAIL load10: got %h want beef0000", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic rw; int lat;
    transact(1'b1, 5'd30, 32'hA1B2C3D4, rd, rw, lat);
    transact(1'b0, 5'd30, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'hA1B2C3D4) begin fails++; $display("FAIL load30_wrap: got %h want a1b2c3d4", rd); end
    transact(1'b0, 5'd0, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'hC3D45678) begin fails++; $display("FAIL load0_after_wrap: got %h want c3d45678", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic rw; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    tests++; if (lat !== 3) begin fails++; $display("FAIL bp_latency: got %0d want 3", lat); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd8; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid); end
      tests++; if (resp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, resp_rdata); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", resp_valid); end
    transact(1'b0, 5'd8, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_not_queued: got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; logic rw; int lat;
    transact(1'b1, 5'd4, 32'h0, rd, rw, lat);
    transact(1'b0, 5'd8, 32'h0, rd, rw, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd4; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_req_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL midrst_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_write !== 1'b0) begin fails++; $display("FAIL midrst_resp_write: got %b want 0", resp_write); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL midrst_resp_rdata: got %h want 0", resp_rdata); end
    repeat (4) @(negedge clk);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_late_resp: got %b want 0", resp_valid); end
    transact(1'b0, 5'd4, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL midrst_mem4: got %h want 0", rd); end
  endtask

  task automatic test_reset_at_commit;
    logic [31:0] rd; logic rw; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd4; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL commitrst_valid: got %b want 0", resp_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL commitrst_ready: got %b want 1", req_ready); end
    transact(1'b0, 5'd4, 32'h0, rd, rw, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL commitrst_mem4: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back;
    int acc [3];
    int rsp_cyc [3];
    logic [31:0] rsp_data [3];
    logic rsp_wr [3];
    int idx = 0;
    int nr = 0;
    logic need_update = 1'b0;
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 5'd0; req_wdata1 = 32'h0A0B0C0D;
    resp_ready1 = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (resp_valid1 && nr < 3) begin
        rsp_cyc[nr] = cyc; rsp_data[nr] = resp_rdata1; rsp_wr[nr] = resp_write1; nr++;
      end
      if (req_ready1 && req_valid1 && idx < 3) begin
        acc[idx] = cyc; idx++; need_update = 1'b1;
      end else if (need_update) begin
        need_update = 1'b0;
        if (idx < 3) begin req_write1 = 1'b0; req_addr1 = 5'd0; end
        else req_valid1 = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready1 = 1'b0;
    tests++; if (idx !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
    tests++; if (nr !== 3) begin fails++; $display("FAIL b2b_responses: got %0d want 3", nr); end
    if (idx == 3 && nr == 3) begin
      tests++; if (acc[1] - acc[0] !== 3) begin fails++; $display("FAIL b2b_spacing01: got %0d want 3", acc[1] - acc[0]); end
      tests++; if (acc[2] - acc[1] !== 3) begin fails++; $display("FAIL b2b_spacing12: got %0d want 3", acc[2] - acc[1]); end
      tests++; if (rsp_cyc[0] - acc[0] !== 2) begin fails++; $display("FAIL b2b_latency: got %0d want 2", rsp_cyc[0] - acc[0]); end
      tests++; if (rsp_wr[0] !== 1'b1 || rsp_data[0] !== 32'h0) begin fails++; $display("FAIL b2b_store_resp: got %b/%h want 1/0", rsp_wr[0], rsp_data[0]); end
      tests++; if (rsp_wr[1] !== 1'b0 || rsp_data[1] !== 32'h0A0B0C0D) begin fails++; $display("FAIL b2b_load1: got %b/%h want 0/0a0b0c0d", rsp_wr[1], rsp_data[1]); end
      tests++; if (rsp_data[2] !== 32'h0A0B0C0D) begin fails++; $display("FAIL b2b_load2: got %h want 0a0b0c0d", rsp_data[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_load();
    test_wrap();
    test_backpressure();
    test_reset_mid_store();
    test_reset_at_commit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
